// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte/state types and substitution FSM encoding
package aes_pkg;

  localparam int AES_N = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [AES_N-1:0][AES_N-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t byte_in,
  output byte_t byte_out
);

  // Index 0 sits at the left of the concatenation, so row r lists entries 16r..16r+15.
  localparam byte_t [0:255] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_out = INV_SBOX[byte_in];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative InvSubBytes, LANES shared inverse S-boxes per cycle
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int N     = 4,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][N-1:0][7:0]  bytes_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0][N-1:0][7:0]  bytes_out,
  output logic                      busy
);

  localparam int NN = N * N;
  localparam int G  = NN / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  if ((NN % LANES) != 0) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must divide N*N");
  end

  fsm_state_e         state_q, state_d;
  logic [GW-1:0]      grp_q, grp_d;
  byte_t [NN-1:0]     sbytes_q, sbytes_d;
  byte_t [LANES-1:0]  lane_in;
  byte_t [LANES-1:0]  lane_out;

  // Flat byte k of the packed state is row k/N, column k%N.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = sbytes_q[KW'(int'(grp_q) * LANES + l)];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .byte_in  (lane_in[l]),
      .byte_out (lane_out[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    sbytes_d = sbytes_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sbytes_d = bytes_in;
          grp_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          sbytes_d[KW'(int'(grp_q) * LANES + l)] = lane_out[l];
        end
        if (grp_q == GW'(G - 1)) begin
          grp_d   = '0;
          state_d = ST_DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      sbytes_q <= '0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      sbytes_q <= sbytes_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign bytes_out = sbytes_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - directed self-checking bench for inv_sub_bytes_iter
module tb_inv_sub_bytes_iter;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst;
  logic   in_valid, in_ready, out_valid, out_ready, busy;
  state_t bytes_in, bytes_out;
  logic   in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  state_t bytes_out_a;
  logic   in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  state_t bytes_out_b;

  int n_cmp = 0;
  int n_err = 0;

  state_t ks, ke, ps, pe, rs, re;
  logic   ov_seen;
  int     la, lb;

  inv_sub_bytes_iter #(.N(4), .LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bytes_in(bytes_in),
    .out_valid(out_valid), .out_ready(out_ready), .bytes_out(bytes_out), .busy(busy)
  );

  inv_sub_bytes_iter #(.N(4), .LANES(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .bytes_in(bytes_in),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .bytes_out(bytes_out_a), .busy(busy_a)
  );

  inv_sub_bytes_iter #(.N(4), .LANES(16)) u_dut_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .bytes_in(bytes_in),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .bytes_out(bytes_out_b), .busy(busy_b)
  );

  function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
    byte_t a = a_in;
    byte_t b = b_in;
    byte_t p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic byte_t ginv(input byte_t x);
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, byte_t'(y)) == 8'h01) return byte_t'(y);
    end
    return 8'h00;
  endfunction

  // Forward S-box built from field inversion plus the affine map.
  function automatic byte_t fsbox(input byte_t x);
    byte_t b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input state_t s);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    bytes_in = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int c = 0;
    while (!out_valid && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_latency"}, c, exp_lat);
  endtask

  task automatic run_txn(input string tag, input state_t s, input state_t e);
    send(tag, s);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_in_ready_run"}, in_ready, 1'b0);
    wait_out(tag, 4);
    chk({tag, "_data"}, bytes_out, e);
    tick();
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready = 1'b1; out_ready_a = 1'b0; out_ready_b = 1'b0;
    bytes_in = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bytes_out", bytes_out, 128'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_l1_out_valid", out_valid_a, 1'b0);
    chk("rst_l16_out_valid", out_valid_b, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    run_txn("zeros", '0, {16{8'h52}});

    ks = '0;
    ks[0][0] = 8'h63; ks[0][1] = 8'h7c; ks[0][2] = 8'h16; ks[0][3] = 8'hed;
    ke = {16{8'h52}};
    ke[0][0] = 8'h00; ke[0][1] = 8'h01; ke[0][2] = 8'hff; ke[0][3] = 8'h53;
    run_txn("known", ks, ke);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pe[i][j] = byte_t'(8'ha0 + i * 4 + j);
        ps[i][j] = fsbox(pe[i][j]);
      end
    end
    out_ready = 1'b0;
    send("bp", ps);
    wait_out("bp", 4);
    for (int c = 0; c < 10; c++) begin
      chk("bp_data_hold", bytes_out, pe);
      chk("bp_out_valid_hold", out_valid, 1'b1);
      chk("bp_in_ready_low", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);

    send("midrun", ks);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrun_busy", busy, 1'b0);
    chk("midrun_bytes_out", bytes_out, 128'h0);
    chk("midrun_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) ov_seen = 1'b1;
    end
    chk("midrun_no_out_valid", ov_seen, 1'b0);
    run_txn("after_reset", ks, ke);

    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          re[i][j] = byte_t'(s * 16 + i * 4 + j);
          rs[i][j] = fsbox(re[i][j]);
        end
      end
      run_txn("roundtrip", rs, re);
    end

    bytes_in = ks;
    chk("cfg_l1_in_ready", in_ready_a, 1'b1);
    chk("cfg_l16_in_ready", in_ready_b, 1'b1);
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    tick();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    la = -1;
    lb = -1;
    for (int c = 0; c < 30; c++) begin
      if (la < 0 && out_valid_a) la = c;
      if (lb < 0 && out_valid_b) lb = c;
      tick();
    end
    chk("cfg_l1_latency", la, 16);
    chk("cfg_l16_latency", lb, 1);
    chk("cfg_l1_data", bytes_out_a, ke);
    chk("cfg_l16_data", bytes_out_b, ke);
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    tick();
    chk("cfg_l1_done", out_valid_a, 1'b0);
    chk("cfg_l16_done", out_valid_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
